// File: rtl/seq_mult_pkg.sv
// Shared definitions for the parametrised shift-add multiplier:
// FSM state encodings and the step-counter width helper.
package seq_mult_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter must hold every step index 0..n, hence clog2(n+1).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// Combinational partial-product unit: multiplies the magnitude of A by a
// BITS_PER_CYCLE-bit slice of B and aligns the result to the step position.
module seq_mult_step
    import seq_mult_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1,
    parameter int CW             = 4
) (
    input  logic [WIDTH-1:0]          mag_a,
    input  logic [BITS_PER_CYCLE-1:0] slice,
    input  logic [CW-1:0]             step,
    output logic [2*WIDTH-1:0]        addend
);

    logic [2*WIDTH-1:0] mag_ext;
    logic [2*WIDTH-1:0] partial;

    always_comb begin
        mag_ext = {{WIDTH{1'b0}}, mag_a};
        partial = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (slice[j]) begin
                partial = partial + (mag_ext << j);
            end
        end
        // Step k retires multiplier bits [k*BPC +: BPC], so weight by 2^(k*BPC).
        addend = partial << (int'(step) * BITS_PER_CYCLE);
    end

endmodule

// File: rtl/seq_multiplier_param.sv
// Sequential shift-add multiplier with valid/ready operand and result ports,
// configurable width, bits retired per cycle and per-operation signed mode.
module seq_multiplier_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   C
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready/valid are registered and decoded from state only.
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = cnt_width(N);

    logic [1:0]         state, state_next;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic               neg;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_next, addend;
    logic               accept, last_step;

    assign accept    = in_valid && in_ready;
    assign last_step = (cnt == CW'(N - 1));
    assign in_mag_a  = (signed_mode && A[WIDTH-1]) ? -A : A;
    assign in_mag_b  = (signed_mode && B[WIDTH-1]) ? -B : B;
    assign acc_next  = acc + addend;

    seq_mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .CW             (CW)
    ) u_step (
        .mag_a  (mag_a),
        .slice  (mag_b[BITS_PER_CYCLE-1:0]),
        .step   (cnt),
        .addend (addend)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            C         <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag_a <= in_mag_a;
                        mag_b <= in_mag_b;
                        neg   <= signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mag_b <= mag_b >> BITS_PER_CYCLE;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        C <= neg ? -acc_next : acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Bench for seq_multiplier_param: directed 8x8 cases on one instance and a
// random sweep over three WIDTH=16 instances driven in lock-step.
module tb_seq_multiplier_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // WIDTH=8, BITS_PER_CYCLE=1 instance
    logic        in_valid8 = 1'b0, in_ready8, mode8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        out_valid8, out_ready8 = 1'b1;
    logic [15:0] c8;

    // WIDTH=16 instances with BITS_PER_CYCLE 1, 2, 4 sharing inputs
    logic        in_valid16 = 1'b0, mode16 = 1'b0, out_ready16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic [2:0]  rdy16, ov16;
    logic [31:0] c16 [3];

    int check_cnt = 0;
    int err_cnt   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    seq_multiplier_param #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .signed_mode(mode8), .A(a8), .B(b8), .out_valid(out_valid8),
        .out_ready(out_ready8), .C(c8)
    );

    seq_multiplier_param #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut16_1 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(rdy16[0]),
        .signed_mode(mode16), .A(a16), .B(b16), .out_valid(ov16[0]),
        .out_ready(out_ready16), .C(c16[0])
    );

    seq_multiplier_param #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut16_2 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(rdy16[1]),
        .signed_mode(mode16), .A(a16), .B(b16), .out_valid(ov16[1]),
        .out_ready(out_ready16), .C(c16[1])
    );

    seq_multiplier_param #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16_4 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(rdy16[2]),
        .signed_mode(mode16), .A(a16), .B(b16), .out_valid(ov16[2]),
        .out_ready(out_ready16), .C(c16[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision product of the operands as integers, truncated.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic sgn, input int w);
        longint sa, sb, p;
        if (w == 8) begin
            sa = sgn ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            sb = sgn ? longint'($signed(b[7:0])) : longint'(b[7:0]);
            p  = sa * sb;
            return {16'h0, p[15:0]};
        end
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        return p[31:0];
    endfunction

    // One 8-bit operation; optionally scramble inputs during CALC and stall the output.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                        input logic [15:0] exp, input bit toggle, input int hold);
        int cycles;
        logic [31:0] want;
        exp_q.push_back({16'h0, exp});
        check("ref8", ref_mul({8'h0, a}, {8'h0, b}, sgn, 8), {16'h0, exp});
        @(negedge clk);
        check("in_ready8_idle", {31'h0, in_ready8}, 32'd1);
        a8 = a; b8 = b; mode8 = sgn; in_valid8 = 1'b1;
        out_ready8 = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        cycles = 0;
        while (!out_valid8 && cycles < 40) begin
            if (toggle) begin
                a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        want = exp_q.pop_front();
        check("latency8", cycles, 32'd8);
        check("product8", {16'h0, c8}, want);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid8", {31'h0, out_valid8}, 32'd1);
            check("hold_c8", {16'h0, c8}, want);
            check("hold_ready8", {31'h0, in_ready8}, 32'd0);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        check("ready_after8", {31'h0, in_ready8}, 32'd1);
        check("valid_low8", {31'h0, out_valid8}, 32'd0);
        check("c_kept8", {16'h0, c8}, want);
    endtask

    function automatic logic [15:0] pick16();
        logic [15:0] corner [5];
        corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h8000;
        corner[3] = 16'hFFFF; corner[4] = 16'h7FFF;
        if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    // One operand pair broadcast to all three 16-bit instances.
    task automatic run16();
        int cycles;
        logic [2:0] seen;
        int lat [3];
        lat[0] = 16; lat[1] = 8; lat[2] = 4;
        @(negedge clk);
        check("rdy16", {29'h0, rdy16}, 32'd7);
        a16 = pick16(); b16 = pick16(); mode16 = 1'($urandom);
        exp_q.push_back(ref_mul(a16, b16, mode16, 16));
        in_valid16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); mode16 = 1'($urandom);
        seen = '0;
        cycles = 0;
        while (seen != 3'b111 && cycles < 40) begin
            @(negedge clk);
            cycles++;
            for (int i = 0; i < 3; i++) begin
                if (ov16[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    check("latency16", cycles, lat[i]);
                    check("product16", c16[i], exp_q[0]);
                end
            end
        end
        check("done16", {29'h0, seen}, 32'd7);
        void'(exp_q.pop_front());
    endtask

    initial begin
        #12;
        check("rst_in_ready8", {31'h0, in_ready8}, 32'd1);
        check("rst_out_valid8", {31'h0, out_valid8}, 32'd0);
        check("rst_c8", {16'h0, c8}, 32'd0);
        check("rst_rdy16", {29'h0, rdy16}, 32'd7);
        check("rst_ov16", {29'h0, ov16}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run8(8'h55, 8'h18, 1'b0, 16'h07F8, 1'b0, 0);
        run8(8'h99, 8'h41, 1'b0, 16'h26D9, 1'b0, 0);
        run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 0);
        run8(8'h99, 8'h41, 1'b1, 16'hE5D9, 1'b0, 0);
        run8(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0, 0);
        run8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, 0);
        run8(8'h99, 8'h41, 1'b1, 16'hE5D9, 1'b1, 20);
        run8(8'h55, 8'h18, 1'b0, 16'h07F8, 1'b1, 3);

        // Abort an operation mid-CALC with an asynchronous reset.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; mode8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_c8", {16'h0, c8}, 32'd0);
        check("midrst_valid8", {31'h0, out_valid8}, 32'd0);
        check("midrst_ready8", {31'h0, in_ready8}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run8(8'h03, 8'h05, 1'b0, 16'h000F, 1'b0, 0);

        for (int k = 0; k < 1000; k++) begin
            run16();
        end

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_param.md
# seq_multiplier_param

Parametrised sequential shift-add multiplier, the successor to the fixed 8×8 enable-driven multiplier. It adds a configurable operand width, a configurable number of multiplier bits retired per cycle, and per-operation signed/unsigned mode. Operands are captured through a valid/ready handshake and the product is returned through one. It sits as a datapath slave between a controller that issues operand pairs and a consumer that may stall.

## Interface
- WIDTH, 8, operand width in bits; product is 2*WIDTH; legal values are ≥ 2.
- BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; must divide WIDTH; legal values are 1, 2, 4.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair and mode are valid.
- in_ready  output  1  block can accept an operand pair.
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned; sampled at acceptance.
- A  input  WIDTH  multiplicand.
- B  input  WIDTH  multiplier.
- out_valid  output  1  C holds a finished product.
- out_ready  input  1  consumer takes C.
- C  output  2*WIDTH  product register.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: busy.
  - DONE: out_valid=1.
- IDLE → CALC on in_valid & in_ready. At acceptance:
  - A, B and signed_mode are registered.
  - In signed mode each operand is converted to magnitude and the sign flag is set to sign(A) XOR sign(B).
  - Accumulator and step counter are cleared.
- Most-negative operand: magnitude of 100…0 is 2^(WIDTH-1), which fits unsigned in WIDTH bits; no special case.
- CALC step:
  - Each edge adds (magB low BITS_PER_CYCLE bits) × magA, shifted by the step position, into the 2*WIDTH accumulator.
  - magB is shifted right by BITS_PER_CYCLE.
  - The counter increments.
- CALC → DONE on the edge that completes step N = WIDTH/BITS_PER_CYCLE. On that edge C is loaded with the accumulator, two's-complement negated if the sign flag is set. Arithmetic is modulo 2^(2*WIDTH).
- DONE → IDLE on out_ready. C holds its value until the next product is loaded; it is not cleared on leaving DONE.
- Input changes while not in IDLE are ignored: operands are latched, so A, B and signed_mode may change freely during CALC.
- No acceptance in the same cycle as the DONE→IDLE handshake; in_ready rises the cycle after.
- Reset at any time, including mid-CALC or in DONE: state returns to IDLE, C=0, accumulator=0, counter=0, out_valid=0, in_ready=1. A partially computed product is discarded.

## Timing
- Reset values:
  - in_ready=1.
  - out_valid=0.
  - C=0.
- Latency: out_valid rises exactly N cycles after the accepting edge. WIDTH=8 gives 8 cycles at BITS_PER_CYCLE=1, 4 cycles at 2, and 2 cycles at 4.
- Throughput: one product per N+2 cycles when out_ready is held high.
- out_valid stays high and C stays stable for as long as out_ready=0, with no limit.
- in_ready and out_valid are registered, decoded from state only, and never high together.

## Structure
- Shared package seq_mult_pkg holds:
  - State encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - A counter-width function (clog2 of N+1).
- One sub-module seq_mult_step: combinational partial-product unit taking magA, a BITS_PER_CYCLE-bit multiplier slice and the step index, and producing the shifted 2*WIDTH addend. The top instantiates it once.
- The top holds:
  - the FSM,
  - operand and magnitude registers,
  - the accumulator,
  - the counter,
  - the sign fix-up.

## Test plan
- Unsigned basic, WIDTH=8, BITS_PER_CYCLE=1, signed_mode=0: A=0x55, B=0x18 → C=0x07F8, with out_valid exactly 8 cycles after acceptance.
- Unsigned large: A=0x99, B=0x41 → C=0x26D9. Repeat with A=0xFF, B=0xFF → C=0xFE01.
- Signed mode:
  - A=0x99, B=0x41 → C=0xE5D9 (−6695).
  - A=0xFF, B=0xFF → C=0x0001.
  - A=0x80, B=0x80 → C=0x4000.
- Backpressure and input isolation:
  - Hold out_ready=0 for 20 cycles after out_valid: C and out_valid stay stable and in_ready stays 0.
  - Toggle A and B during CALC: the result is unchanged.
  - After out_ready, in_ready=1 on the next cycle.
- Reset mid-CALC: assert rst 3 cycles after acceptance → immediately C=0, out_valid=0, in_ready=1. A following A=0x03, B=0x05 → C=0x000F.
- Parameter sweep: with WIDTH=16 and BITS_PER_CYCLE 1, 2 and 4, run 1000 random operand pairs in both modes against a reference model. Latency must be 16, 8 and 4 cycles respectively.
